// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: one command in, one pipelined SINGLE/INCR/INCRx/WRAPx burst out; two-cycle ERROR aborts it.
// First NONSEQ one cycle after accept, done two cycles after the last address phase; HREADY=0 stalls everything, cmd_ready only in IDLE.
module ahb_burst_master #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         SLAVES_NUM = 4,
    parameter int         MAX_BEATS  = 16,
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    localparam int        SEL_W      = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1,
    localparam int        LEN_W      = $clog2(MAX_BEATS) + 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [SEL_W-1:0]      cmd_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  err,
    output logic [SEL_W-1:0]      HSEL,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
    localparam int CNT_W    = (LEN_W > 5) ? LEN_W : 5;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_BEATS);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [SEL_W-1:0]      hsel_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [2:0]            hburst_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic [CNT_W-1:0]      beats_left_q;
    logic                  nseq_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  done_q;
    logic                  err_q;

    logic [CNT_W-1:0]      cmd_beats;
    logic [CNT_W-1:0]      cmd_len_ext;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  cross_1k;
    logic                  size_ok;
    logic                  accept;
    logic                  addr_adv;
    logic                  last_addr;
    logic                  dp_act;
    logic                  dp_done;
    logic                  dp_err1;

    assign size_ok   = (cmd_size <= 3'(MAX_SIZE));
    assign accept    = (state_q == S_IDLE) && cmd_valid;
    assign addr_adv  = ((state_q == S_ADDR) || (state_q == S_BURST)) && HREADY;
    assign last_addr = (beats_left_q == CNT_W'(1));
    assign dp_act    = (state_q == S_BURST) || (state_q == S_LAST);
    assign dp_done   = dp_act && HREADY && !HRESP;
    assign dp_err1   = dp_act && HRESP && !HREADY;

    // Beat count of the incoming command; undefined-length INCR is clamped to 1..MAX_BEATS.
    assign cmd_len_ext = CNT_W'(cmd_len);
    always_comb begin
        cmd_beats = CNT_W'(16);
        case (cmd_burst)
            3'b000: cmd_beats = CNT_W'(1);
            3'b001: begin
                if (cmd_len_ext == '0)
                    cmd_beats = CNT_W'(1);
                else if (cmd_len_ext > MAX_LEN)
                    cmd_beats = MAX_LEN;
                else
                    cmd_beats = cmd_len_ext;
            end
            3'b010, 3'b011: cmd_beats = CNT_W'(4);
            3'b100, 3'b101: cmd_beats = CNT_W'(8);
            default:        cmd_beats = CNT_W'(16);
        endcase
    end

    // Non-wrapping bursts use an all-ones mask so the merge below degenerates to a plain increment.
    always_comb begin
        addr_inc  = ADDR_WIDTH'(1) << hsize_q;
        incr_addr = haddr_q + addr_inc;
        case (hburst_q)
            3'b010:  wrap_mask = (ADDR_WIDTH'(4)  << hsize_q) - ADDR_WIDTH'(1);
            3'b100:  wrap_mask = (ADDR_WIDTH'(8)  << hsize_q) - ADDR_WIDTH'(1);
            3'b110:  wrap_mask = (ADDR_WIDTH'(16) << hsize_q) - ADDR_WIDTH'(1);
            default: wrap_mask = '1;
        endcase
        next_addr = (haddr_q & ~wrap_mask) | (incr_addr & wrap_mask);
        cross_1k  = (hburst_q == 3'b001) &&
                    (next_addr[ADDR_WIDTH-1:10] != haddr_q[ADDR_WIDTH-1:10]);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && size_ok) state_d = S_ADDR;
            S_ADDR:  if (HREADY) state_d = last_addr ? S_LAST : S_BURST;
            S_BURST: begin
                if (dp_err1)
                    state_d = S_ERR;
                else if (HREADY)
                    state_d = last_addr ? S_LAST : S_BURST;
            end
            S_LAST: begin
                if (dp_err1)
                    state_d = S_ERR;
                else if (HREADY)
                    state_d = S_IDLE;
            end
            S_ERR:   if (HREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ERR is entered with the pending address phase already withdrawn; done/err fire on the closing ERROR cycle.
    always_comb begin
        cmd_ready = 1'b0;
        HTRANS    = TR_IDLE;
        HPROT     = '0;
        wr_req    = 1'b0;
        done      = done_q;
        err       = err_q;
        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_ADDR: begin
                HTRANS = TR_NONSEQ;
                HPROT  = HPROT_VAL;
                wr_req = HREADY && hwrite_q;
            end
            S_BURST: begin
                HTRANS = nseq_q ? TR_NONSEQ : TR_SEQ;
                HPROT  = HPROT_VAL;
                wr_req = HREADY && hwrite_q;
            end
            S_LAST: HPROT = HPROT_VAL;
            S_ERR: begin
                HPROT = HPROT_VAL;
                done  = done_q | HREADY;
                err   = err_q | HREADY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsel_q       <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hburst_q     <= '0;
            haddr_q      <= '0;
            beats_left_q <= '0;
            nseq_q       <= 1'b0;
            hwdata_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;

            if (accept) begin
                if (size_ok) begin
                    hsel_q       <= cmd_sel;
                    hwrite_q     <= cmd_write;
                    hsize_q      <= cmd_size;
                    hburst_q     <= cmd_burst;
                    haddr_q      <= cmd_addr;
                    beats_left_q <= cmd_beats;
                    nseq_q       <= 1'b0;
                end else begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end
            end

            // The final address stays on HADDR during the closing data phase.
            if (addr_adv) begin
                beats_left_q <= beats_left_q - CNT_W'(1);
                if (!last_addr) begin
                    haddr_q <= next_addr;
                    nseq_q  <= cross_1k;
                end
                if (hwrite_q)
                    hwdata_q <= wr_data;
            end

            if (dp_done && !hwrite_q) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= HRDATA;
            end

            if ((state_q == S_LAST) && HREADY) begin
                done_q <= 1'b1;
                err_q  <= HRESP;
            end
        end
    end

    assign HSEL     = hsel_q;
    assign HADDR    = haddr_q;
    assign HWRITE   = hwrite_q;
    assign HSIZE    = hsize_q;
    assign HBURST   = hburst_q;
    assign HWDATA   = hwdata_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: each burst is walked cycle by cycle against hand-derived AHB timelines.
module tb_ahb_burst_master;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst, cmd_size;
    logic [4:0]  cmd_len;
    logic [1:0]  cmd_sel;
    logic [31:0] wr_data, rd_data;
    logic        wr_req, rd_valid, done, err;
    logic [1:0]  HSEL, HTRANS;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_burst_master dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .err(err),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] b,
                         input logic [4:0] l, input logic [2:0] s, input logic [1:0] sel);
        cmd_write = wr;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_len   = l;
        cmd_size  = s;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
    endtask

    logic [31:0] wrap_exp [8];

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_burst = 0; cmd_len = 0;
        cmd_size = 0; cmd_sel = 0; wr_data = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
        wrap_exp = '{32'h34, 32'h38, 32'h3C, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30};

        // Reset values
        #1 HRESETn = 1'b0;
        #1;
        chk("rst.cmd_ready", 64'(cmd_ready), 1);
        chk("rst.htrans",    64'(HTRANS),    0);
        chk("rst.haddr",     64'(HADDR),     0);
        chk("rst.hwdata",    64'(HWDATA),    0);
        chk("rst.hprot",     64'(HPROT),     0);
        chk("rst.done",      64'(done),      0);
        chk("rst.err",       64'(err),       0);
        chk("rst.wr_req",    64'(wr_req),    0);
        chk("rst.rd_valid",  64'(rd_valid),  0);
        tick; tick;
        HRESETn = 1'b1;
        tick;

        // SINGLE write 0x100
        issue(1'b1, 32'h100, 3'b000, 5'd0, 3'd2, 2'd2);
        #1 chk("t1.accept_rdy", 64'(cmd_ready), 1);
        tick; cmd_valid = 0; wr_data = 32'hA5A5A5A5; #1;
        chk("t1.c1.htrans", 64'(HTRANS), 2);
        chk("t1.c1.haddr",  64'(HADDR),  64'h100);
        chk("t1.c1.hwrite", 64'(HWRITE), 1);
        chk("t1.c1.hsel",   64'(HSEL),   2);
        chk("t1.c1.hsize",  64'(HSIZE),  2);
        chk("t1.c1.hburst", 64'(HBURST), 0);
        chk("t1.c1.hprot",  64'(HPROT),  3);
        chk("t1.c1.wr_req", 64'(wr_req), 1);
        chk("t1.c1.cmd_ready", 64'(cmd_ready), 0);
        tick; wr_data = 0; #1;
        chk("t1.c2.htrans", 64'(HTRANS), 0);
        chk("t1.c2.hwdata", 64'(HWDATA), 64'hA5A5A5A5);
        chk("t1.c2.wr_req", 64'(wr_req), 0);
        chk("t1.c2.done",   64'(done),   0);
        tick; #1;
        chk("t1.c3.done",      64'(done),      1);
        chk("t1.c3.err",       64'(err),       0);
        chk("t1.c3.cmd_ready", 64'(cmd_ready), 1);
        tick; #1;
        chk("t1.c4.done", 64'(done), 0);

        // INCR4 read from 0x20, HRDATA 1..4 in data phases (cycles 2..5)
        issue(1'b0, 32'h20, 3'b011, 5'd0, 3'd2, 2'd1);
        tick; cmd_valid = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick;
            HRDATA = 32'(c - 1);
            #1;
            if (c <= 4) begin
                chk($sformatf("t2.c%0d.htrans", c), 64'(HTRANS), (c == 1) ? 2 : 3);
                chk($sformatf("t2.c%0d.haddr", c),  64'(HADDR),  64'(32'h20 + 4 * (c - 1)));
            end else begin
                chk($sformatf("t2.c%0d.htrans", c), 64'(HTRANS), 0);
            end
            chk($sformatf("t2.c%0d.rd_valid", c), 64'(rd_valid), (c >= 3) ? 1 : 0);
            if (c >= 3)
                chk($sformatf("t2.c%0d.rd_data", c), 64'(rd_data), 64'(c - 2));
            chk($sformatf("t2.c%0d.done", c),   64'(done),   (c == 6) ? 1 : 0);
            chk($sformatf("t2.c%0d.wr_req", c), 64'(wr_req), 0);
        end

        // WRAP8 write from 0x34; the following command is issued in the done cycle
        tick; HRDATA = 0;
        issue(1'b1, 32'h34, 3'b100, 5'd0, 3'd2, 2'd1);
        tick; cmd_valid = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick;
            wr_data = (c <= 8) ? 32'h1000 + 32'(c) : 32'h0;
            if (c == 10) issue(1'b0, 32'h200, 3'b001, 5'd3, 3'd2, 2'd0);
            #1;
            if (c <= 8) begin
                chk($sformatf("t3.c%0d.haddr", c),  64'(HADDR),  64'(wrap_exp[c - 1]));
                chk($sformatf("t3.c%0d.htrans", c), 64'(HTRANS), (c == 1) ? 2 : 3);
                chk($sformatf("t3.c%0d.wr_req", c), 64'(wr_req), 1);
            end else begin
                chk($sformatf("t3.c%0d.htrans", c), 64'(HTRANS), 0);
                chk($sformatf("t3.c%0d.wr_req", c), 64'(wr_req), 0);
            end
            if (c >= 2 && c <= 9)
                chk($sformatf("t3.c%0d.hwdata", c), 64'(HWDATA), 64'(32'h1000 + 32'(c - 1)));
            chk($sformatf("t3.c%0d.done", c), 64'(done), (c == 10) ? 1 : 0);
        end
        chk("t3.c10.cmd_ready", 64'(cmd_ready), 1);

        // INCR len 3 read from 0x200, beat 2 data phase stalled two cycles
        tick; cmd_valid = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick;
            HREADY = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            HRDATA = (c == 2) ? 32'h11 : (c == 5) ? 32'h22 : (c == 6) ? 32'h33 : 32'h0;
            #1;
            if (c == 1) begin
                chk("t4.c1.htrans", 64'(HTRANS), 2);
                chk("t4.c1.haddr",  64'(HADDR),  64'h200);
            end else if (c == 2) begin
                chk("t4.c2.htrans", 64'(HTRANS), 3);
                chk("t4.c2.haddr",  64'(HADDR),  64'h204);
            end else if (c <= 5) begin
                chk($sformatf("t4.c%0d.htrans", c), 64'(HTRANS), 3);
                chk($sformatf("t4.c%0d.haddr", c),  64'(HADDR),  64'h208);
                chk($sformatf("t4.c%0d.hburst", c), 64'(HBURST), 1);
            end else begin
                chk($sformatf("t4.c%0d.htrans", c), 64'(HTRANS), 0);
            end
            chk($sformatf("t4.c%0d.rd_valid", c), 64'(rd_valid),
                (c == 3 || c == 6 || c == 7) ? 1 : 0);
            if (c == 3) chk("t4.c3.rd_data", 64'(rd_data), 64'h11);
            if (c == 6) chk("t4.c6.rd_data", 64'(rd_data), 64'h22);
            if (c == 7) chk("t4.c7.rd_data", 64'(rd_data), 64'h33);
            chk($sformatf("t4.c%0d.done", c), 64'(done), (c == 7) ? 1 : 0);
        end

        // INCR16 write from 0x400, ERROR on beat 5 data phase (cycles 6 and 7)
        tick;
        issue(1'b1, 32'h400, 3'b111, 5'd0, 3'd2, 2'd3);
        tick; cmd_valid = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick;
            wr_data = 32'h2000 + 32'(c);
            HRESP   = (c == 6 || c == 7) ? 1'b1 : 1'b0;
            HREADY  = (c == 6) ? 1'b0 : 1'b1;
            #1;
            if (c <= 6) begin
                chk($sformatf("t5.c%0d.haddr", c),  64'(HADDR),  64'(32'h400 + 4 * (c - 1)));
                chk($sformatf("t5.c%0d.htrans", c), 64'(HTRANS), (c == 1) ? 2 : 3);
            end else begin
                chk($sformatf("t5.c%0d.htrans", c), 64'(HTRANS), 0);
            end
            chk($sformatf("t5.c%0d.wr_req", c), 64'(wr_req), (c <= 5) ? 1 : 0);
            chk($sformatf("t5.c%0d.done", c),   64'(done),   (c == 7) ? 1 : 0);
            chk($sformatf("t5.c%0d.err", c),    64'(err),    (c == 7) ? 1 : 0);
            if (c == 6 || c == 7)
                chk($sformatf("t5.c%0d.hwdata", c), 64'(HWDATA), 64'h2005);
            chk($sformatf("t5.c%0d.rd_valid", c), 64'(rd_valid), 0);
        end
        chk("t5.c8.cmd_ready", 64'(cmd_ready), 1);

        // Oversized command is rejected without bus activity
        tick;
        issue(1'b0, 32'h40, 3'b000, 5'd0, 3'd3, 2'd0);
        tick; cmd_valid = 0; #1;
        chk("t6.c1.done",      64'(done),      1);
        chk("t6.c1.err",       64'(err),       1);
        chk("t6.c1.htrans",    64'(HTRANS),    0);
        chk("t6.c1.cmd_ready", 64'(cmd_ready), 1);
        tick; #1;
        chk("t6.c2.done", 64'(done), 0);
        chk("t6.c2.err",  64'(err),  0);

        // INCR with cmd_len 0 behaves as one halfword beat
        issue(1'b0, 32'h80, 3'b001, 5'd0, 3'd1, 2'd0);
        tick; cmd_valid = 0; #1;
        chk("t7.c1.htrans", 64'(HTRANS), 2);
        chk("t7.c1.haddr",  64'(HADDR),  64'h80);
        chk("t7.c1.hsize",  64'(HSIZE),  1);
        tick; HRDATA = 32'h77; #1;
        chk("t7.c2.htrans", 64'(HTRANS), 0);
        tick; HRDATA = 0; #1;
        chk("t7.c3.done",     64'(done),     1);
        chk("t7.c3.rd_valid", 64'(rd_valid), 1);
        chk("t7.c3.rd_data",  64'(rd_data),  64'h77);

        // INCR len 4 from 0x3F8 crosses 1 KB on beat 3; reset hits mid-burst
        tick;
        issue(1'b1, 32'h3F8, 3'b001, 5'd4, 3'd2, 2'd3);
        tick; cmd_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick;
            wr_data = 32'h3000 + 32'(c);
            #1;
            chk($sformatf("t8.c%0d.htrans", c), 64'(HTRANS), (c == 1 || c == 3) ? 2 : 3);
            chk($sformatf("t8.c%0d.haddr", c),  64'(HADDR),  64'(32'h3F8 + 4 * (c - 1)));
        end
        HRESETn = 1'b0;
        #1;
        chk("t8.rst.htrans",    64'(HTRANS),    0);
        chk("t8.rst.cmd_ready", 64'(cmd_ready), 1);
        chk("t8.rst.haddr",     64'(HADDR),     0);
        chk("t8.rst.hsel",      64'(HSEL),      0);
        chk("t8.rst.hwrite",    64'(HWRITE),    0);
        chk("t8.rst.hwdata",    64'(HWDATA),    0);
        chk("t8.rst.wr_req",    64'(wr_req),    0);
        chk("t8.rst.hprot",     64'(HPROT),     0);
        chk("t8.rst.done",      64'(done),      0);
        tick; #1;
        chk("t8.rst2.done",   64'(done),   0);
        chk("t8.rst2.htrans", 64'(HTRANS), 0);
        HRESETn = 1'b1;
        tick; #1;
        chk("t8.post.done",      64'(done),      0);
        chk("t8.post.cmd_ready", 64'(cmd_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
